dispatch_ctrl: RTL
==================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter: ROB_W, default `ROB_WIDTH_BIT, ROB entry index width.
REQ-002 clk_in  in  1  system clock; all state on rising edge.
REQ-003 rst_in  in  1  reset, asynchronous, active-low.
REQ-004 rdy_in  in  1  when low, block holds all state and drives every pulse output 0.
REQ-005 rob_clear  in  1  pipeline flush.
REQ-006 iq_valid/iq_ready  in/out  1/1  instruction-queue handshake; pop when both high.
REQ-007 iq_rd, iq_rs1, iq_rs2  in  5 each  decoded register ids.
REQ-008 iq_uses_rs2  in  1  instruction reads rs2.
REQ-009 rob_full/rs_full  in  1/1  ROB and reservation-station occupancy.
REQ-010 rob_tail  in  ROB_W  ROB id the next allocation receives.
REQ-011 rf_get_id1/rf_get_id2  out  5/5  register-file read ids.
REQ-012 rf_val1/rf_val2  in  32/32  read values, ROB-forwarded.
REQ-013 rf_has_dep1/rf_has_dep2  in  1/1  operand still pending.
REQ-014 rf_dep1/rf_dep2  in  ROB_W/ROB_W  producing ROB id.
REQ-015 rf_set_dep_reg_id/rf_set_dep_rob_id  out  5/ROB_W  rename write to the register file; id 0 means none.
REQ-016 cdb_valid/cdb_rob_id/cdb_val  in  1/ROB_W/32  result broadcast.
REQ-017 rob_alloc/rs_issue  out  1/1  one-cycle allocate/issue pulses.
REQ-018 rs_val1/rs_val2  out  32/32  operand values.
REQ-019 rs_has_dep1/rs_has_dep2  out  1/1  operand pending.
REQ-020 rs_dep1/rs_dep2  out  ROB_W/ROB_W  operand tags.
REQ-021 rs_rob_id  out  ROB_W  entry id sent with the issue.

Function
REQ-022 FSM states: IDLE, READ, HOLD.
REQ-023 IDLE: iq_ready = iq_valid && !rob_clear, combinational; on the pop, latch rd/rs1/rs2/uses_rs2 and go to READ.
REQ-024 READ: rf_get_id1=rs1 and rf_get_id2=rs2; at the edge, capture val/has_dep/dep per operand into operand registers, then go to HOLD.
REQ-025 Operand forcing: rs1==0 or (rs2==0 or !uses_rs2) captures val=0, has_dep=0, dep=0 for that operand.
REQ-026 Snoop: at the READ capture and every HOLD cycle, cdb_valid && has_dep && dep==cdb_rob_id sets val=cdb_val, has_dep=0, dep=0.
REQ-026a Snoop priority: the snooped value wins over the register-file value in the same cycle.
REQ-027 HOLD with !rob_full && !rs_full, in one combinational cycle:
  - rob_alloc=1, rs_issue=1, rs_rob_id=rob_tail.
  - rf_set_dep_reg_id=rd, rf_set_dep_rob_id=rob_tail.
  - rs_* driven with operand values post-snoop for the current cycle.
  - Next state IDLE.
REQ-028 HOLD otherwise: stay in HOLD with no pulses, keep snooping.
REQ-029 Throughput: at most one issue per 3 cycles; iq_ready is never high outside IDLE.
REQ-030 rd==0: issue proceeds with rf_set_dep_reg_id=0.
REQ-030a Self-dependence: rd==rs1 or rd==rs2 captures the old dependence, because the capture precedes the rename.
REQ-031 rob_clear (rdy_in high): any state goes to IDLE next cycle; latched instruction discarded; that cycle rob_alloc, rs_issue, iq_ready and rf_set_dep_reg_id are 0.
REQ-032 rob_clear is a priority event: it overrides any issue condition or snoop in the same cycle.
REQ-033 Outside the issue cycle: rf_set_dep_reg_id=0; rs_* hold last operand registers; rf_get_id* hold latched ids.
REQ-034 rdy_in low overrides everything except reset; rob_clear is ignored while rdy_in is low.

Reset
REQ-035 rst_in low, asynchronously and regardless of clk_in or rdy_in:
  - State IDLE; latched fields and operand registers 0.
  - All outputs 0.
REQ-036 Reset mid-HOLD drops the instruction; no issue pulse appears at reset release.

Verification
REQ-037 Basic issue: rd=5, rs1=1, rs2=2; rf has_dep=0, val1=0x10, val2=0x20; rob_tail=3 -> iq_ready cycle 0; rob_alloc=rs_issue=1 cycle 2; rs_val1=0x10, rs_val2=0x20, rs_rob_id=3; rf_set_dep_reg_id=5, rf_set_dep_rob_id=3.
REQ-038 Dependence plus snoop: rs1 has_dep=1, dep=4; cdb_valid with cdb_rob_id=4, cdb_val=0xABCD during HOLD -> rs_has_dep1=0, rs_val1=0xABCD at issue.
REQ-039 Stall: rs_full=1 for 5 HOLD cycles -> no pulses, iq_ready=0; issue exactly one cycle after rs_full falls; rob_tail sampled in that cycle.
REQ-040 Flush: rob_clear in HOLD with rob_full=0 and rs_full=0 -> no rob_alloc, rs_issue or rf_set_dep; IDLE next cycle; the next queued instruction pops normally.
REQ-041 Corner ids: rd=0, rs1=0, iq_uses_rs2=0 -> rf_set_dep_reg_id=0, rs_val1=rs_val2=0, both has_dep=0.
REQ-042 Pause: rdy_in low for 3 cycles in READ -> state and outputs frozen, pulses 0; capture resumes on the first rdy_in-high edge.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
// Instruction-queue to dispatch handshake bundle.
// The queue drives a decoded instruction; dispatch answers with ready.
interface dispatch_ctrl_if;
  logic       iq_valid;
  logic       iq_ready;
  logic [4:0] iq_rd;
  logic [4:0] iq_rs1;
  logic [4:0] iq_rs2;
  logic       iq_uses_rs2;

  modport master (
    output iq_valid,
    output iq_rd,
    output iq_rs1,
    output iq_rs2,
    output iq_uses_rs2,
    input  iq_ready
  );

  modport slave (
    input  iq_valid,
    input  iq_rd,
    input  iq_rs1,
    input  iq_rs2,
    input  iq_uses_rs2,
    output iq_ready
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Single-issue dispatch: pop, read operands, then allocate ROB and
// issue to the reservation station while snooping the CDB.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module dispatch_ctrl #(
  parameter int ROB_W = `ROB_WIDTH_BIT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  dispatch_ctrl_if.slave   iq,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic [ROB_W-1:0] rob_tail,
  output logic [4:0]       rf_get_id1,
  output logic [4:0]       rf_get_id2,
  input  logic [31:0]      rf_val1,
  input  logic [31:0]      rf_val2,
  input  logic             rf_has_dep1,
  input  logic             rf_has_dep2,
  input  logic [ROB_W-1:0] rf_dep1,
  input  logic [ROB_W-1:0] rf_dep2,
  output logic [4:0]       rf_set_dep_reg_id,
  output logic [ROB_W-1:0] rf_set_dep_rob_id,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_val,
  output logic             rob_alloc,
  output logic             rs_issue,
  output logic [31:0]      rs_val1,
  output logic [31:0]      rs_val2,
  output logic             rs_has_dep1,
  output logic             rs_has_dep2,
  output logic [ROB_W-1:0] rs_dep1,
  output logic [ROB_W-1:0] rs_dep2,
  output logic [ROB_W-1:0] rs_rob_id
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  typedef struct packed {
    logic [31:0]      val;
    logic             has_dep;
    logic [ROB_W-1:0] dep;
  } op_t;

  function automatic op_t snoop(
    input op_t              o,
    input logic             hit_v,
    input logic [ROB_W-1:0] hit_id,
    input logic [31:0]      hit_val
  );
    op_t r;
    r = o;
    if (hit_v && o.has_dep && (o.dep == hit_id)) begin
      r.val     = hit_val;
      r.has_dep = 1'b0;
      r.dep     = '0;
    end
    return r;
  endfunction

  state_t     state;
  state_t     state_n;
  logic [4:0] rd_q;
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  logic       use2_q;
  op_t        op1_q;
  op_t        op2_q;
  op_t        op1_n;
  op_t        op2_n;
  op_t        rf_op1;
  op_t        rf_op2;
  op_t        cap1;
  op_t        cap2;
  op_t        snp1;
  op_t        snp2;
  op_t        out1;
  op_t        out2;
  logic       pop;
  logic       issue;
  logic       live;

  assign live = rst_in && rdy_in;

  // Snooped value beats the register-file value in the capture cycle.
  always_comb begin
    rf_op1 = {rf_val1, rf_has_dep1, rf_dep1};
    rf_op2 = {rf_val2, rf_has_dep2, rf_dep2};
    cap1   = '0;
    cap2   = '0;
    if (rs1_q != 5'd0) begin
      cap1 = snoop(rf_op1, cdb_valid, cdb_rob_id, cdb_val);
    end
    if ((rs2_q != 5'd0) && use2_q) begin
      cap2 = snoop(rf_op2, cdb_valid, cdb_rob_id, cdb_val);
    end
    snp1 = snoop(op1_q, cdb_valid, cdb_rob_id, cdb_val);
    snp2 = snoop(op2_q, cdb_valid, cdb_rob_id, cdb_val);
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    issue   = 1'b0;
    op1_n   = op1_q;
    op2_n   = op2_q;
    if (live && rob_clear) begin
      state_n = IDLE;
    end else if (live) begin
      unique case (state)
        IDLE: begin
          pop = iq.iq_valid;
          if (pop) begin
            state_n = READ;
          end
        end
        READ: begin
          op1_n   = cap1;
          op2_n   = cap2;
          state_n = HOLD;
        end
        HOLD: begin
          op1_n = snp1;
          op2_n = snp2;
          issue = !rob_full && !rs_full;
          if (issue) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      use2_q <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      state <= state_n;
      op1_q <= op1_n;
      op2_q <= op2_n;
      if (pop) begin
        rd_q   <= iq.iq_rd;
        rs1_q  <= iq.iq_rs1;
        rs2_q  <= iq.iq_rs2;
        use2_q <= iq.iq_uses_rs2;
      end
    end
  end

  // The issue cycle forwards this cycle's snoop straight to the RS.
  assign out1 = issue ? op1_n : op1_q;
  assign out2 = issue ? op2_n : op2_q;

  assign iq.iq_ready = pop;
  assign rob_alloc   = issue;
  assign rs_issue    = issue;
  assign rs_rob_id   = issue ? rob_tail : '0;

  assign rf_set_dep_reg_id = issue ? rd_q : 5'd0;
  assign rf_set_dep_rob_id = issue ? rob_tail : '0;

  assign rf_get_id1 = rs1_q;
  assign rf_get_id2 = rs2_q;

  assign rs_val1     = out1.val;
  assign rs_val2     = out2.val;
  assign rs_has_dep1 = out1.has_dep;
  assign rs_has_dep2 = out2.has_dep;
  assign rs_dep1     = out1.dep;
  assign rs_dep2     = out2.dep;

endmodule
